// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter and sequencer that shares one UART
// transmit FSM among NUM_REQ byte producers.
//
// Ports:
//   clk, reset_n     rising-edge clock, synchronous active-low reset
//   req, req_data    per-requester byte-valid and packed bytes (i at [i*DATA_LEN +: DATA_LEN])
//   grant            one-hot 1-cycle pulse: byte of requester i accepted
//   tx_done          transmitter ready (1) / frame in progress (0)
//   tx_en, tx_data   launch pulse and byte toward the transmitter
//   owner            index of the requester whose frame is in flight
//   busy             high whenever the sequencer is not idle
//   frame_done       1-cycle pulse when the transmitter returns to ready after a frame
//   timeout_err      1-cycle pulse when a launch is never acknowledged
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IDX_W    = 2,
    parameter int unsigned DATA_LEN = 8,
    parameter int unsigned START_TO = 6
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_LEN-1:0] req_data,
    output logic [NUM_REQ-1:0]          grant,
    input  logic                        tx_done,
    output logic                        tx_en,
    output logic [DATA_LEN-1:0]         tx_data,
    output logic [IDX_W-1:0]            owner,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        timeout_err
);

    localparam int unsigned TMR_W = (START_TO > 2) ? $clog2(START_TO) : 2;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        WAIT_END
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic                  tx_en_q, tx_en_d;
    logic [DATA_LEN-1:0]   tx_data_q, tx_data_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  timeout_q, timeout_d;

    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      cand;
    logic [DATA_LEN-1:0]   win_byte;

    // Round-robin pick: first asserted request at or after ptr, wrapping.
    always_comb begin : arb_pick
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        win_byte  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == win_idx) begin
                win_byte = req_data[i*DATA_LEN +: DATA_LEN];
            end
        end
    end

    // Next-state and registered-output values.
    always_comb begin : fsm_next
        state_d      = state_q;
        ptr_d        = ptr_q;
        timer_d      = timer_q;
        owner_d      = owner_q;
        tx_data_d    = tx_data_q;
        grant_d      = '0;
        tx_en_d      = 1'b0;
        frame_done_d = 1'b0;
        timeout_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_done && win_found) begin
                    tx_data_d = win_byte;
                    owner_d   = win_idx;
                    grant_d   = NUM_REQ'(1) << win_idx;
                    ptr_d     = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                // tx_en is registered, so it is visible during the first WAIT_START cycle.
                tx_en_d = 1'b1;
                timer_d = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (!tx_done) begin
                    state_d = WAIT_END;
                end else if (timer_q == TMR_W'(START_TO - 1)) begin
                    // Byte is dropped; pointer already advanced past the owner.
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            WAIT_END: begin
                if (tx_done) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin : regs
        if (!reset_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            timer_q      <= '0;
            grant_q      <= '0;
            tx_en_q      <= 1'b0;
            tx_data_q    <= '0;
            owner_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            timer_q      <= timer_d;
            grant_q      <= grant_d;
            tx_en_q      <= tx_en_d;
            tx_data_q    <= tx_data_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign tx_en       = tx_en_q;
    assign tx_data     = tx_data_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_q;

endmodule
